alu_seq: RTL and testbench

Multi-cycle command sequencer that drives the 16-bit combinational ALU as its initiator. It holds an 8-entry register file and accepts one command per handshake: opcode, two source indices and one destination index. It presents the operands and opcode to the ALU, captures `out`/`Z`, and writes the result back. It sits between the instruction-decode logic and the ALU.

---
 rtl/alu_seq.sv | 140 ++++++++++++++
 tb/tb_alu_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - 4-state command sequencer driving a 16-bit combinational ALU; optional status flag via `ALU_SEQ_STATUS_EN
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  localparam int IW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IW-1:0]    cmd_rn,
  input  logic [IW-1:0]    cmd_rm,
  input  logic [IW-1:0]    cmd_rd,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] alu_ain,
  output logic [WIDTH-1:0] alu_bin,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z_flag
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_READ = 2'b01;
  localparam logic [1:0] S_EXEC = 2'b10;
  localparam logic [1:0] S_WB   = 2'b11;

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [IW-1:0]    r_rn;
  logic [IW-1:0]    r_rm;
  logic [IW-1:0]    r_rd;
  logic [WIDTH-1:0] r_ain;
  logic [WIDTH-1:0] r_bin;
  logic [1:0]       r_aop;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_regs [NREG];
  logic             w_accept;

  assign w_accept  = cmd_valid && cmd_ready;
  assign cmd_ready = (r_state == S_IDLE);
  assign done      = (r_state == S_WB);
  assign alu_ain   = r_ain;
  assign alu_bin   = r_bin;
  assign alu_op    = r_aop;
  assign result    = r_result;

  // Sequencer state: one command walks IDLE -> READ -> EXEC -> WB -> IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) r_state <= S_READ;
        S_READ:  r_state <= S_EXEC;
        S_EXEC:  r_state <= S_WB;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Command fields are latched at accept and held for the whole operation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= 2'b00;
      r_rn <= '0;
      r_rm <= '0;
      r_rd <= '0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_op <= cmd_op;
      r_rn <= cmd_rn;
      r_rm <= cmd_rm;
      r_rd <= cmd_rd;
    end
  end

  // ALU operands and opcode only move on READ -> EXEC so the ALU inputs stay quiet otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ain <= '0;
      r_bin <= '0;
      r_aop <= 2'b00;
    end else if (r_state == S_READ) begin
      r_ain <= r_regs[r_rn];
      r_bin <= r_regs[r_rm];
      r_aop <= r_op;
    end
  end

  // Result capture at the end of EXEC; holds until the next command's EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
    end else if (r_state == S_EXEC) begin
      r_result <= alu_out;
    end
  end

  // Register file: host write first, write-back second so write-back wins on an index collision
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        r_regs[wr_addr] <= wr_data;
      end
      if (r_state == S_WB) begin
        r_regs[r_rd] <= r_result;
      end
    end
  end

`ifdef ALU_SEQ_STATUS_EN
  logic r_z;

  // Zero flag captured alongside the result at the end of EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      r_z <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_z <= alu_z;
    end
  end

  assign z_flag = r_z;
`else
  logic w_unused_z;

  assign w_unused_z = alu_z;
  assign z_flag     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a behavioural ALU attached
module tb_alu_seq;

  localparam int WIDTH = 16;
  localparam int NREG  = 8;
  localparam int IW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [IW-1:0]    cmd_rn;
  logic [IW-1:0]    cmd_rm;
  logic [IW-1:0]    cmd_rd;
  logic             wr_en;
  logic [IW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] alu_ain;
  logic [WIDTH-1:0] alu_bin;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_z;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             z_flag;

  alu_seq #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_rd(cmd_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z),
    .done(done), .result(result), .z_flag(z_flag)
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU the sequencer is the initiator of
  always_comb begin
    case (alu_op)
      2'b00:   alu_out = alu_ain + alu_bin;
      2'b01:   alu_out = alu_ain - alu_bin;
      2'b10:   alu_out = alu_ain & alu_bin;
      default: alu_out = ~alu_bin;
    endcase
  end
  assign alu_z = (alu_out == '0);

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_res;
    logic        exp_z;
  } vec_t;

  vec_t vecs [7];

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]  last_op;
  logic [1:0]  c_rd_op;
  logic [1:0]  c_ex_op;
  logic [15:0] c_ex_a;
  logic [15:0] c_ex_b;
  logic [15:0] c_res;
  logic [15:0] c_res_after;
  logic        c_z;
  logic        c_z_after;
  logic        c_done_after;
  int          c_lat;
  int          c_rdy_low;
  logic [15:0] rb;
  logic [1:0]  prev_op;
  int          acc [$];
  int          ndone;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_flag(input logic z);
`ifdef ALU_SEQ_STATUS_EN
    return z;
`else
    return 1'b0 & z;
`endif
  endfunction

  task automatic hwrite(input logic [IW-1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Issue one command and record what is seen in each phase; optional host write during WB
  task automatic run_cmd(input logic [1:0] op, input logic [IW-1:0] rn, input logic [IW-1:0] rm,
                         input logic [IW-1:0] rd, input logic hw_en, input logic [IW-1:0] hw_addr,
                         input logic [15:0] hw_data);
    int w;
    cmd_valid = 1'b1; cmd_op = op; cmd_rn = rn; cmd_rm = rm; cmd_rd = rd;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    c_rd_op   = alu_op;
    c_lat     = 1;
    c_rdy_low = cmd_ready ? 0 : 1;
    c_ex_op   = 2'bxx; c_ex_a = 'x; c_ex_b = 'x;
    while (!done && c_lat < 10) begin
      @(posedge clk); #1; c_lat++;
      if (!cmd_ready) c_rdy_low++;
      if (c_lat == 2) begin
        c_ex_op = alu_op; c_ex_a = alu_ain; c_ex_b = alu_bin;
      end
    end
    c_res = result; c_z = z_flag;
    wr_en = hw_en; wr_addr = hw_addr; wr_data = hw_data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    c_res_after = result; c_z_after = z_flag; c_done_after = done;
    last_op = op;
  endtask

  // R[idx] + R0 written back to itself; R0 stays zero for the whole run
  task automatic read_reg(input logic [IW-1:0] idx, output logic [15:0] v);
    run_cmd(2'b00, idx, 3'd0, idx, 1'b0, 3'd0, 16'h0);
    v = c_res;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"add",      2'b00, 16'h0005, 16'h0005, 16'h000A, 1'b0};
    vecs[1] = '{"sub",      2'b01, 16'h000A, 16'h0005, 16'h0005, 1'b0};
    vecs[2] = '{"and_zero", 2'b10, 16'h0005, 16'h0002, 16'h0000, 1'b1};
    vecs[3] = '{"not",      2'b11, 16'h1234, 16'h0000, 16'hFFFF, 1'b0};
    vecs[4] = '{"add_wrap", 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[5] = '{"sub_neg",  2'b01, 16'h0003, 16'h0005, 16'hFFFE, 1'b0};
    vecs[6] = '{"and_mask", 2'b10, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rn = '0; cmd_rm = '0; cmd_rd = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; last_op = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    // Host write during reset must be discarded
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hFFFF;
    @(posedge clk); #1;
    wr_en = 1'b0; reset = 1'b0;

    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_z_flag", z_flag, 0);
    check("rst_alu_ain", alu_ain, 0);
    check("rst_alu_bin", alu_bin, 0);
    check("rst_alu_op", alu_op, 0);
    read_reg(3'd5, rb);
    check("rst_r5_zero", rb, 16'h0000);

    // Table-driven ALU operations: rn=1, rm=2, rd=3
    for (int i = 0; i < 7; i++) begin
      hwrite(3'd1, vecs[i].a);
      hwrite(3'd2, vecs[i].b);
      prev_op = last_op;
      run_cmd(vecs[i].op, 3'd1, 3'd2, 3'd3, 1'b0, 3'd0, 16'h0);
      check({vecs[i].name, "_latency"}, c_lat, 3);
      check({vecs[i].name, "_ready_low"}, c_rdy_low, 3);
      check({vecs[i].name, "_read_alu_op"}, c_rd_op, prev_op);
      check({vecs[i].name, "_exec_alu_op"}, c_ex_op, vecs[i].op);
      check({vecs[i].name, "_exec_ain"}, c_ex_a, vecs[i].a);
      check({vecs[i].name, "_exec_bin"}, c_ex_b, vecs[i].b);
      check({vecs[i].name, "_result"}, c_res, vecs[i].exp_res);
      check({vecs[i].name, "_z_flag"}, c_z, exp_flag(vecs[i].exp_z));
      check({vecs[i].name, "_done_pulse"}, c_done_after, 0);
      check({vecs[i].name, "_result_hold"}, c_res_after, vecs[i].exp_res);
      check({vecs[i].name, "_z_hold"}, c_z_after, exp_flag(vecs[i].exp_z));
      read_reg(3'd3, rb);
      check({vecs[i].name, "_r3_readback"}, rb, vecs[i].exp_res);
    end

    // rd equal to a source: R1 = R1 + R1, then reuse in the next command
    hwrite(3'd1, 16'h0003);
    run_cmd(2'b00, 3'd1, 3'd1, 3'd1, 1'b0, 3'd0, 16'h0);
    run_cmd(2'b00, 3'd1, 3'd1, 3'd1, 1'b0, 3'd0, 16'h0);
    check("rd_eq_rn_chain", c_res, 16'h000C);

    // Write-back and host write collide on R3: write-back wins
    hwrite(3'd1, 16'h0005);
    hwrite(3'd2, 16'h0005);
    run_cmd(2'b00, 3'd1, 3'd2, 3'd3, 1'b1, 3'd3, 16'h1234);
    read_reg(3'd3, rb);
    check("collide_r3", rb, 16'h000A);
    // Host write to another index at the write-back edge also lands
    hwrite(3'd3, 16'h0000);
    run_cmd(2'b00, 3'd1, 3'd2, 3'd3, 1'b1, 3'd4, 16'h0BEE);
    read_reg(3'd4, rb);
    check("parallel_r4", rb, 16'h0BEE);
    read_reg(3'd3, rb);
    check("parallel_r3", rb, 16'h000A);

    // Handshake: cmd_valid held high, accepts every 4 cycles
    hwrite(3'd1, 16'h0011);
    hwrite(3'd2, 16'h0022);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rn = 3'd1; cmd_rm = 3'd2; cmd_rd = 3'd5;
    ndone = 0;
    acc.delete();
    for (int c = 0; c < 18; c++) begin
      if (cmd_ready) acc.push_back(c);
      if (done) ndone++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    for (int w = 0; w < 10 && !cmd_ready; w++) begin
      @(posedge clk); #1;
    end
    check("hs_accept_count", acc.size(), 5);
    for (int k = 1; k < acc.size(); k++) begin
      check("hs_accept_gap", acc[k] - acc[k-1], 4);
    end
    check("hs_done_count", ndone, 4);
    read_reg(3'd5, rb);
    check("hs_r5", rb, 16'h0033);

    // Reset asserted during EXEC aborts the command
    hwrite(3'd1, 16'h0007);
    hwrite(3'd2, 16'h0008);
    check("rx_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_rn = 3'd1; cmd_rm = 3'd2; cmd_rd = 3'd6;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("rx_in_exec_op", alu_op, 2'b01);
    check("rx_in_exec_ain", alu_ain, 16'h0007);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rx_cmd_ready", cmd_ready, 1);
    check("rx_done", done, 0);
    check("rx_result", result, 0);
    check("rx_z_flag", z_flag, 0);
    check("rx_alu_ain", alu_ain, 0);
    check("rx_alu_bin", alu_bin, 0);
    check("rx_alu_op", alu_op, 0);
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    check("rx_no_done", ndone, 0);
    read_reg(3'd6, rb);
    check("rx_r6_unwritten", rb, 16'h0000);
    read_reg(3'd1, rb);
    check("rx_r1_cleared", rb, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
